// File: rtl/vram_write_scheduler.sv
// Arbitrates CPU bus writes (small FIFO) and a block-fill engine onto the tile/attr/color VRAM write ports.
// Optional VRAM_BLANK_GATE_EN adds a blanking input; grants then only happen while blanking is high.
module vram_write_scheduler #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] ATTR_BASE  = 16'h0800,
   parameter logic [15:0] COLOR_BASE = 16'h1800
) (
   input  logic        clk,
   input  logic        rst,
`ifdef VRAM_BLANK_GATE_EN
   input  logic        blanking,
`endif
   input  logic        cpu_wr_valid,
   input  logic [15:0] cpu_wr_addr,
   input  logic [7:0]  cpu_wr_data,
   output logic        cpu_fifo_full,
   output logic        cpu_overflow,
   input  logic        fill_start,
   input  logic [15:0] fill_base,
   input  logic [15:0] fill_len,
   input  logic [7:0]  fill_value,
   output logic        fill_busy,
   output logic        fill_done,
   output logic        tile_we,
   output logic [10:0] tile_addr,
   output logic [7:0]  tile_data,
   output logic        attr_we,
   output logic [11:0] attr_addr,
   output logic [7:0]  attr_data,
   output logic        color_we,
   output logic [3:0]  color_addr,
   output logic [7:0]  color_data
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fill_state_t;
   typedef enum logic {RR_CPU, RR_FILL} rr_t;

   logic [15:0]   fifo_addr_q [FIFO_DEPTH];
   logic [7:0]    fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, overflow_q;

   fill_state_t   state_q;
   logic [15:0]   cur_q, rem_q;
   logic [7:0]    val_q;
   logic          busy_q, done_q;
   rr_t           rr_q;

   logic          gate_ok, cpu_req, fill_req, contested;
   logic          grant_cpu, grant_fill, push, pop;
   logic [15:0]   wr_addr;
   logic [7:0]    wr_data;
   logic [11:0]   attr_off;

`ifdef VRAM_BLANK_GATE_EN
   assign gate_ok = blanking;
`else
   assign gate_ok = 1'b1;
`endif

   assign cpu_req   = (count_q != '0);
   assign fill_req  = (state_q == S_RUN);
   assign contested = gate_ok & cpu_req & fill_req;

   always_comb begin
      grant_cpu  = 1'b0;
      grant_fill = 1'b0;
      if (gate_ok) begin
         if (cpu_req && fill_req) begin
            grant_cpu  = (rr_q == RR_CPU);
            grant_fill = (rr_q == RR_FILL);
         end else begin
            grant_cpu  = cpu_req;
            grant_fill = fill_req;
         end
      end
   end

   // A full queue still accepts a push when the same clk pops an entry.
   assign pop     = grant_cpu;
   assign push    = cpu_wr_valid && ((count_q < CW'(FIFO_DEPTH)) || pop);
   assign count_d = count_q + CW'(push) - CW'(pop);

   assign wr_addr  = grant_cpu ? fifo_addr_q[rd_ptr_q] : cur_q;
   assign wr_data  = grant_cpu ? fifo_data_q[rd_ptr_q] : val_q;
   assign attr_off = wr_addr[11:0] - ATTR_BASE[11:0];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= cpu_wr_addr;
         fifo_data_q[wr_ptr_q] <= cpu_wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         rr_q       <= RR_CPU;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q    <= count_d;
         full_q     <= (count_d == CW'(FIFO_DEPTH));
         overflow_q <= overflow_q | (cpu_wr_valid & ~push);
         if (contested) rr_q <= (rr_q == RR_CPU) ? RR_FILL : RR_CPU;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         rem_q   <= '0;
         val_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (fill_start) begin
                  if (fill_len == 16'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                     cur_q   <= fill_base;
                     rem_q   <= fill_len;
                     val_q   <= fill_value;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (grant_fill) begin
                  cur_q <= cur_q + 16'd1;
                  rem_q <= rem_q - 16'd1;
                  if (rem_q == 16'd1) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tile_we    <= 1'b0;
         tile_addr  <= '0;
         tile_data  <= '0;
         attr_we    <= 1'b0;
         attr_addr  <= '0;
         attr_data  <= '0;
         color_we   <= 1'b0;
         color_addr <= '0;
         color_data <= '0;
      end else begin
         tile_we  <= 1'b0;
         attr_we  <= 1'b0;
         color_we <= 1'b0;
         if (grant_cpu || grant_fill) begin
            if (wr_addr < ATTR_BASE) begin
               tile_we   <= 1'b1;
               tile_addr <= wr_addr[10:0];
               tile_data <= wr_data;
            end else if (wr_addr < COLOR_BASE) begin
               attr_we   <= 1'b1;
               attr_addr <= attr_off;
               attr_data <= wr_data;
            end else begin
               color_we   <= 1'b1;
               color_addr <= wr_addr[3:0];
               color_data <= wr_data;
            end
         end
      end
   end

   assign cpu_fifo_full = full_q;
   assign cpu_overflow  = overflow_q;
   assign fill_busy     = busy_q;
   assign fill_done     = done_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler; writes are captured per clk and compared to hand-computed lists.
// The blanking-gate scenario is built only when VRAM_BLANK_GATE_EN is defined.
module tb_vram_write_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
`ifdef VRAM_BLANK_GATE_EN
   logic        blanking = 1'b1;
`endif
   logic        cpu_wr_valid = 1'b0;
   logic [15:0] cpu_wr_addr = '0;
   logic [7:0]  cpu_wr_data = '0;
   logic        cpu_fifo_full, cpu_overflow;
   logic        fill_start = 1'b0;
   logic [15:0] fill_base = '0;
   logic [15:0] fill_len = '0;
   logic [7:0]  fill_value = '0;
   logic        fill_busy, fill_done;
   logic        tile_we, attr_we, color_we;
   logic [10:0] tile_addr;
   logic [11:0] attr_addr;
   logic [3:0]  color_addr;
   logic [7:0]  tile_data, attr_data, color_data;

   vram_write_scheduler #(.FIFO_DEPTH(4), .ATTR_BASE(16'h0800), .COLOR_BASE(16'h1800)) dut (
      .clk(clk), .rst(rst),
`ifdef VRAM_BLANK_GATE_EN
      .blanking(blanking),
`endif
      .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
      .cpu_fifo_full(cpu_fifo_full), .cpu_overflow(cpu_overflow),
      .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_value(fill_value),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .tile_we(tile_we), .tile_addr(tile_addr), .tile_data(tile_data),
      .attr_we(attr_we), .attr_addr(attr_addr), .attr_data(attr_data),
      .color_we(color_we), .color_addr(color_addr), .color_data(color_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  port;   // 0 tile, 1 attr, 2 color
      logic [11:0] addr;
      logic [7:0]  data;
      logic [31:0] edge_n;
   } wr_t;

   wr_t         obs[$];
   int unsigned edge_cnt = 0;
   int unsigned busy_cnt = 0;
   int unsigned done_cnt = 0;
   int unsigned done_edge = 0;
   int unsigned multi_we = 0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if ((32'(tile_we) + 32'(attr_we) + 32'(color_we)) > 1) multi_we++;
         if (tile_we)  obs.push_back({2'd0, {1'b0, tile_addr}, tile_data, edge_cnt});
         if (attr_we)  obs.push_back({2'd1, attr_addr, attr_data, edge_cnt});
         if (color_we) obs.push_back({2'd2, {8'd0, color_addr}, color_data, edge_cnt});
         if (fill_busy) busy_cnt++;
         if (fill_done) begin
            done_cnt++;
            done_edge = edge_cnt;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next();
      @(negedge clk);
   endtask

   task automatic clear_mon();
      obs.delete();
      busy_cnt = 0;
      done_cnt = 0;
      multi_we = 0;
   endtask

   task automatic do_reset();
      cpu_wr_valid = 1'b0;
      fill_start   = 1'b0;
`ifdef VRAM_BLANK_GATE_EN
      blanking     = 1'b1;
`endif
      rst = 1'b1;
      next();
      next();
      check("reset outputs",
            {tile_we, tile_addr, tile_data, attr_we, attr_addr, attr_data,
             color_we, color_addr, color_data},
            64'd0);
      check("reset status", {cpu_fifo_full, cpu_overflow, fill_busy, fill_done}, 64'd0);
      rst = 1'b0;
      clear_mon();
   endtask

   task automatic exp_wr(input int i, input logic [1:0] p, input logic [11:0] a, input logic [7:0] d);
      if (i < obs.size()) begin
         check($sformatf("wr%0d port", i), obs[i].port, p);
         check($sformatf("wr%0d addr", i), obs[i].addr, a);
         check($sformatf("wr%0d data", i), obs[i].data, d);
      end else begin
         check($sformatf("wr%0d present", i), obs.size(), i + 1);
      end
   endtask

   task automatic drive_push(input logic [15:0] a, input logic [7:0] d);
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = a;
      cpu_wr_data  = d;
   endtask

   initial begin
      int unsigned k;
      int unsigned n;

      // single tile write, latency 2
      do_reset();
      next();
      k = edge_cnt;
      drive_push(16'h0005, 8'hAA);
      next();
      cpu_wr_valid = 1'b0;
      repeat (5) next();
      check("t1 nwr", obs.size(), 1);
      exp_wr(0, 2'd0, 12'h005, 8'hAA);
      if (obs.size() > 0) check("t1 latency", obs[0].edge_n - k, 2);

      // attr/color decode and back-to-back ordering
      do_reset();
      next();
      drive_push(16'h0800, 8'h11);
      next();
      drive_push(16'h17FF, 8'h22);
      next();
      drive_push(16'h1813, 8'h33);
      next();
      cpu_wr_valid = 1'b0;
      repeat (5) next();
      check("t2 nwr", obs.size(), 3);
      exp_wr(0, 2'd1, 12'h000, 8'h11);
      exp_wr(1, 2'd1, 12'hFFF, 8'h22);
      exp_wr(2, 2'd2, 12'h003, 8'h33);
      if (obs.size() == 3) check("t2 spacing", obs[2].edge_n - obs[0].edge_n, 2);

      // fill across the 16-bit address wrap
      do_reset();
      next();
      k = edge_cnt;
      fill_start = 1'b1; fill_base = 16'hFFFE; fill_len = 16'd4; fill_value = 8'h00;
      next();
      fill_start = 1'b0;
      repeat (8) next();
      check("t3 nwr", obs.size(), 4);
      exp_wr(0, 2'd2, 12'h00E, 8'h00);
      exp_wr(1, 2'd2, 12'h00F, 8'h00);
      exp_wr(2, 2'd0, 12'h000, 8'h00);
      exp_wr(3, 2'd0, 12'h001, 8'h00);
      check("t3 busy clks", busy_cnt, 4);
      check("t3 done pulses", done_cnt, 1);
      if (obs.size() == 4) begin
         check("t3 first latency", obs[0].edge_n - k, 2);
         check("t3 done edge", done_edge, obs[3].edge_n);
      end

      // zero-length fill
      do_reset();
      next();
      k = edge_cnt;
      fill_start = 1'b1; fill_base = 16'h0040; fill_len = 16'd0; fill_value = 8'hEE;
      next();
      fill_start = 1'b0;
      repeat (4) next();
      check("t4 nwr", obs.size(), 0);
      check("t4 done pulses", done_cnt, 1);
      check("t4 done edge", done_edge - k, 1);
      check("t4 busy clks", busy_cnt, 0);

      // contested: fill len 16 with CPU pushes every clk the queue allows
      do_reset();
      next();
      fill_start = 1'b1; fill_base = 16'h0100; fill_len = 16'd16; fill_value = 8'h5A;
      drive_push(16'h0800, 8'h40);
      n = 1;
      repeat (45) begin
         next();
         fill_start = 1'b0;
         if (n < 16 && !cpu_fifo_full) begin
            drive_push(16'h0800 + 16'(n), 8'h40 + 8'(n));
            n++;
         end else begin
            cpu_wr_valid = 1'b0;
         end
      end
      check("t5 nwr", obs.size(), 32);
      for (int i = 0; i < 16; i++) begin
         exp_wr(2 * i, 2'd1, 12'(i), 8'h40 + 8'(i));
         exp_wr(2 * i + 1, 2'd0, 12'h100 + 12'(i), 8'h5A);
      end
      check("t5 overflow", cpu_overflow, 0);
      check("t5 done pulses", done_cnt, 1);
      if (obs.size() == 32) begin
         check("t5 back to back", obs[31].edge_n - obs[0].edge_n, 31);
         check("t5 done edge", done_edge, obs[31].edge_n);
      end

      // queue overflow while sharing slots with a fill
      do_reset();
      next();
      fill_start = 1'b1; fill_base = 16'h0300; fill_len = 16'd20; fill_value = 8'h77;
      next();
      fill_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) begin
            check("t6 full before 9th", cpu_fifo_full, 1);
            check("t6 no ovf on pop+push", cpu_overflow, 0);
         end
         drive_push(16'h1800 + 16'(i), 8'(i));
         next();
      end
      cpu_wr_valid = 1'b0;
      check("t6 overflow set", cpu_overflow, 1);
      repeat (50) next();
      check("t6 overflow sticky", cpu_overflow, 1);
      check("t6 drained full", cpu_fifo_full, 0);
      check("t6 nwr", obs.size(), 28);
      check("t6 done pulses", done_cnt, 1);

      // reset during a fill
      do_reset();
      next();
      fill_start = 1'b1; fill_base = 16'h0000; fill_len = 16'd10; fill_value = 8'h99;
      next();
      fill_start = 1'b0;
      next();
      next();
      check("t7 writing before rst", tile_we, 1);
      #2 rst = 1'b1;
      #1;
      check("t7 rst outputs",
            {tile_we, tile_addr, tile_data, attr_we, attr_addr, attr_data,
             color_we, color_addr, color_data},
            64'd0);
      check("t7 rst status", {fill_busy, fill_done}, 64'd0);
      next();
      next();
      rst = 1'b0;
      clear_mon();
      repeat (10) next();
      check("t7 nwr after", obs.size(), 0);
      check("t7 done pulses", done_cnt, 0);
      check("t7 busy clks", busy_cnt, 0);

`ifdef VRAM_BLANK_GATE_EN
      // gated: queue fills while blanking is low, then drains
      do_reset();
      blanking = 1'b0;
      next();
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            check("t8 full after 4", cpu_fifo_full, 1);
            check("t8 no ovf yet", cpu_overflow, 0);
         end
         drive_push(16'h0010 + 16'(i), 8'hC0 + 8'(i));
         next();
      end
      cpu_wr_valid = 1'b0;
      check("t8 overflow", cpu_overflow, 1);
      repeat (3) next();
      check("t8 gated nwr", obs.size(), 0);
      blanking = 1'b1;
      repeat (8) next();
      check("t8 drain nwr", obs.size(), 4);
      for (int i = 0; i < 4; i++) exp_wr(i, 2'd0, 12'h010 + 12'(i), 8'hC0 + 8'(i));
      check("t8 full after drain", cpu_fifo_full, 0);
`endif

      check("multi we", multi_we, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
